// File: rtl/char_buf_pkg.sv
// -----------------------------------------------------------------------------
// char_buf_pkg
// Shared definitions for the character-buffer scheduler: FSM state encoding,
// digit/width constants, ASCII codes and the double-dabble step function.
// No ports (package).
// -----------------------------------------------------------------------------
package char_buf_pkg;

  localparam int NUM_DIGITS = 3;            // digits written per job, MS first
  localparam int VAL_W      = 10;           // client value width
  localparam int BCD_W      = 4 * NUM_DIGITS;

  localparam logic [VAL_W-1:0] VAL_MAX    = VAL_W'(999);
  localparam logic [7:0]       BLANK_CHAR = 8'h20;
  localparam logic [7:0]       ASCII_ZERO = 8'h30;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CONV,
    S_WRITE,
    S_DONE
  } state_t;

  // One double-dabble iteration: add 3 to every nibble >= 5, then shift the
  // whole BCD register left by one, pulling in the next binary bit.
  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] b,
                                               input logic             bit_in);
    logic [BCD_W-1:0] a;
    a = b;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (a[4*n +: 4] >= 4'd5) begin
        a[4*n +: 4] = a[4*n +: 4] + 4'd3;
      end
    end
    return {a[BCD_W-2:0], bit_in};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter (double dabble), one bit per clock.
// The first iteration is folded into the start cycle (BCD starts cleared, so
// no add-3 can apply), so the result is stable and done pulses VAL_W cycles
// after start. The result holds until the next start.
// Ports:
//   pclk  - clock
//   rst   - asynchronous active-high reset
//   start - one-cycle pulse, samples val
//   val   - binary input (VAL_W bits)
//   done  - one-cycle pulse, bcd is valid from this cycle on
//   bcd   - packed BCD result, NUM_DIGITS nibbles, MS nibble on top
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import char_buf_pkg::*;
(
  input  logic             pclk,
  input  logic             rst,
  input  logic             start,
  input  logic [VAL_W-1:0] val,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int CNT_W = $clog2(VAL_W);

  logic [VAL_W-1:0] r_sh;
  logic [BCD_W-1:0] r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_active;
  logic             r_done;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_sh     <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_bcd    <= dd_step('0, val[VAL_W-1]);
        r_sh     <= {val[VAL_W-2:0], 1'b0};
        r_cnt    <= CNT_W'(1);
        r_active <= 1'b1;
      end else if (r_active) begin
        r_bcd <= dd_step(r_bcd, r_sh[VAL_W-1]);
        r_sh  <= {r_sh[VAL_W-2:0], 1'b0};
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(VAL_W-1)) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign done = r_done;
  assign bcd  = r_bcd;

endmodule

// File: rtl/char_buf_sched.sv
// -----------------------------------------------------------------------------
// char_buf_sched
// Round-robin scheduler for two "print this number at this buffer address"
// clients. Each job clamps the value to 999, converts it to three decimal
// digits and writes them as ASCII (leading zeros blanked, LS digit always
// numeric) to consecutive 8-bit buffer addresses, then pulses the client ack.
// Optional build macro CHAR_BUF_VBLNK_GATE_EN: when defined, buffer writes are
// only issued while vblnk_in is high and WRITE stalls otherwise; when
// undefined vblnk_in is ignored and a job takes a fixed 15 cycles to ack.
// Ports:
//   pclk, rst            - clock, asynchronous active-high reset
//   vblnk_in             - vertical blanking (used only with the gate macro)
//   req0/addr0/val0/ack0 - client 0 request level, start address, value, ack
//   req1/addr1/val1/ack1 - client 1, same meaning
//   wr_en/wr_addr/wr_data- buffer write port (addr/data 0 when wr_en is 0)
//   busy                 - high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module char_buf_sched
  import char_buf_pkg::*;
(
  input  logic             pclk,
  input  logic             rst,
  input  logic             vblnk_in,
  input  logic             req0,
  input  logic [7:0]       addr0,
  input  logic [VAL_W-1:0] val0,
  output logic             ack0,
  input  logic             req1,
  input  logic [7:0]       addr1,
  input  logic [VAL_W-1:0] val1,
  output logic             ack1,
  output logic             wr_en,
  output logic [7:0]       wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);

  localparam int K_W = $clog2(NUM_DIGITS + 1);

  state_t           r_state;
  logic             r_grant;      // client owning the current job
  logic             r_last;       // client granted most recently
  logic [7:0]       r_addr;
  logic [K_W-1:0]   r_k;          // digits already written
  logic             r_wr_en;
  logic [7:0]       r_wr_addr;
  logic [7:0]       r_wr_data;
  logic             r_ack0;
  logic             r_ack1;
  logic             r_busy;

  logic             w_grant;
  logic [VAL_W-1:0] w_sel_val;
  logic [VAL_W-1:0] w_start_val;
  logic [7:0]       w_sel_addr;
  logic             w_start;
  logic             w_bcd_done;
  logic [BCD_W-1:0] w_bcd;
  logic             w_wr_ok;
  logic             w_issue;
  logic             w_run;
  logic [7:0]       w_char [0:(1<<K_W)-1];

`ifdef CHAR_BUF_VBLNK_GATE_EN
  assign w_wr_ok = vblnk_in;
`else
  logic w_unused_vblnk;
  assign w_unused_vblnk = vblnk_in;
  assign w_wr_ok        = 1'b1;
`endif

  // Contention goes to whoever was not served last; otherwise the requester.
  assign w_grant     = (req0 & req1) ? ~r_last : req1;
  assign w_sel_val   = r_grant ? val1 : val0;
  assign w_sel_addr  = r_grant ? addr1 : addr0;
  assign w_start_val = (w_sel_val > VAL_MAX) ? VAL_MAX : w_sel_val;
  assign w_start     = (r_state == S_LOAD);

  bin2bcd_seq u_bin2bcd (
    .pclk  (pclk),
    .rst   (rst),
    .start (w_start),
    .val   (w_start_val),
    .done  (w_bcd_done),
    .bcd   (w_bcd)
  );

  // ASCII per write slot (slot 0 = MS digit). w_run stays high while every
  // digit so far is zero; those become blanks, except the final digit.
  always_comb begin
    w_run = 1'b1;
    for (int i = 0; i < (1 << K_W); i++) begin
      w_char[i] = 8'h00;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_run = w_run & (w_bcd[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
      if (w_run && (i != NUM_DIGITS - 1)) begin
        w_char[i] = BLANK_CHAR;
      end else begin
        w_char[i] = ASCII_ZERO + {4'd0, w_bcd[4*(NUM_DIGITS-1-i) +: 4]};
      end
    end
  end

  // The first digit is issued on the CONV->WRITE edge so the registered write
  // lines up with the first WRITE cycle; the ack is raised on the edge after
  // the last write.
  assign w_issue = w_wr_ok &&
                   (((r_state == S_CONV) && w_bcd_done) ||
                    ((r_state == S_WRITE) && (r_k != K_W'(NUM_DIGITS))));

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
      r_addr    <= '0;
      r_k       <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req0 | req1) begin
            r_grant <= w_grant;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_addr  <= w_sel_addr;
          r_k     <= '0;
          r_state <= S_CONV;
        end
        S_CONV: begin
          if (w_bcd_done) begin
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_k == K_W'(NUM_DIGITS)) begin
            r_ack0  <= ~r_grant;
            r_ack1  <= r_grant;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_last  <= r_grant;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
      if (w_issue) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_addr + 8'(r_k);
        r_wr_data <= w_char[r_k];
        r_k       <= r_k + K_W'(1);
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign ack0    = r_ack0;
  assign ack1    = r_ack1;
  assign busy    = r_busy;

endmodule

// File: tb/tb_char_buf_sched.sv
// Self-checking bench for char_buf_sched: stimulus pushes expected writes and
// acks (with their expected cycle) into a queue; a monitor pops and compares
// every write/ack the DUT presents.
module tb_char_buf_sched;

  localparam int EV_WR   = 0;
  localparam int EV_ACK0 = 1;
  localparam int EV_ACK1 = 2;

  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;   // -1: cycle not checked
  } ev_t;

  logic       pclk = 1'b0;
  logic       rst  = 1'b0;
  logic       vblnk_in;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] addr0 = '0, addr1 = '0;
  logic [9:0] val0 = '0, val1 = '0;
  logic       ack0, ack1, wr_en, busy;
  logic [7:0] wr_addr, wr_data;

  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;
  ev_t exp_q[$];

  char_buf_sched dut (
    .pclk     (pclk),
    .rst      (rst),
    .vblnk_in (vblnk_in),
    .req0     (req0),
    .addr0    (addr0),
    .val0     (val0),
    .ack0     (ack0),
    .req1     (req1),
    .addr1    (addr1),
    .val1     (val1),
    .ack1     (ack1),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_event(input int kind, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h cyc=%0d want none", kind, a, d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == EV_WR && (e.addr !== a || e.data !== d)) ||
          (e.cyc >= 0 && e.cyc != cyc)) begin
        bad++;
        $display("FAIL event: got kind=%0d addr=%h data=%h cyc=%0d want kind=%0d addr=%h data=%h cyc=%0d",
                 kind, a, d, cyc, e.kind, e.addr, e.data, e.cyc);
      end else if (kind == EV_WR) begin
        $display("write addr=%h data=%h cyc=%0d ok", a, d, cyc);
      end else begin
        $display("ack%0d cyc=%0d ok", kind - 1, cyc);
      end
    end
  endtask

  // Monitor: every write strobe and ack must match the head of the queue.
  always @(negedge pclk) begin
    if (!rst) begin
      if (wr_en) check_event(EV_WR, wr_addr, wr_data);
      if (ack0)  check_event(EV_ACK0, 8'h00, 8'h00);
      if (ack1)  check_event(EV_ACK1, 8'h00, 8'h00);
    end
  end

  // base: cycle in which the idle DUT sees the request (-1 for don't-care).
  task automatic expect_job(input int client, input logic [7:0] a,
                            input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input int base);
    logic [7:0] ch [0:2];
    ev_t e;
    ch[0] = e0; ch[1] = e1; ch[2] = e2;
    for (int k = 0; k < 3; k++) begin
      e.kind = EV_WR;
      e.addr = a + 8'(k);
      e.data = ch[k];
      e.cyc  = (base < 0) ? -1 : base + 12 + k;
      exp_q.push_back(e);
    end
    e.kind = (client == 0) ? EV_ACK0 : EV_ACK1;
    e.addr = 8'h00;
    e.data = 8'h00;
    e.cyc  = (base < 0) ? -1 : base + 15;
    exp_q.push_back(e);
  endtask

  task automatic run_single(input int client, input logic [7:0] a, input logic [9:0] v,
                            input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    bit got;
    @(negedge pclk);
    if (client == 0) begin addr0 = a; val0 = v; req0 = 1'b1; end
    else             begin addr1 = a; val1 = v; req1 = 1'b1; end
    expect_job(client, a, e0, e1, e2, cyc);
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge pclk);
      if (i == 2) begin  // after LOAD: these changes must be ignored
        addr0 = 8'hAA; val0 = 10'd555; addr1 = 8'hBB; val1 = 10'd666;
      end
      if ((client == 0 && ack0) || (client == 1 && ack1)) got = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0;
    if (!got) chk("single_ack_timeout", 0, 1);
  endtask

  // Both clients keep requesting; each drops req for the cycle after its ack.
  task automatic stress(input int first, input int njobs);
    int n0, n1;
    @(negedge pclk);
    addr0 = 8'h05; val0 = 10'd123; addr1 = 8'hFE; val1 = 10'd7;
    for (int j = 0; j < njobs; j++) begin
      if (((first + j) % 2) == 0) expect_job(0, 8'h05, 8'h31, 8'h32, 8'h33, cyc + 16 * j);
      else                        expect_job(1, 8'hFE, 8'h20, 8'h20, 8'h37, cyc + 16 * j);
    end
    n0 = njobs / 2; n1 = njobs / 2;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 40 * njobs && (n0 > 0 || n1 > 0); c++) begin
      @(negedge pclk);
      if (ack0) begin req0 = 1'b0; n0--; end else if (n0 > 0) req0 = 1'b1;
      if (ack1) begin req1 = 1'b0; n1--; end else if (n1 > 0) req1 = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("stress_pending_jobs", n0 + n1, 0);
  endtask

  initial begin
`ifdef CHAR_BUF_VBLNK_GATE_EN
    vblnk_in = 1'b1;
`else
    vblnk_in = 1'b0;   // ungated build must ignore this
`endif
    #1 rst = 1'b1;
    #2;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    @(negedge pclk);
    chk("post_rst_busy", busy, 0);

    // Simultaneous requests from reset: client 0 first, strict alternation.
    stress(0, 10);

    run_single(0, 8'h05, 10'd123,  8'h31, 8'h32, 8'h33);
    run_single(1, 8'hFE, 10'd7,    8'h20, 8'h20, 8'h37);
    run_single(1, 8'h10, 10'd0,    8'h20, 8'h20, 8'h30);
    run_single(0, 8'h20, 10'd1000, 8'h39, 8'h39, 8'h39);
    run_single(0, 8'h30, 10'd1023, 8'h39, 8'h39, 8'h39);
    run_single(1, 8'h40, 10'd50,   8'h20, 8'h35, 8'h30);
    run_single(0, 8'hFF, 10'd100,  8'h31, 8'h30, 8'h30);
    run_single(1, 8'h80, 10'd999,  8'h39, 8'h39, 8'h39);

    // Last served was client 1, so contention now goes to client 0; serve
    // client 0 alone, then contention must favour client 1.
    run_single(0, 8'h70, 10'd8, 8'h20, 8'h20, 8'h38);
    stress(1, 2);

    // Reset in the middle of CONV: job dropped, no ack, then normal service.
    @(negedge pclk);
    addr0 = 8'h50; val0 = 10'd456; req0 = 1'b1;
    repeat (5) @(negedge pclk);
    chk("mid_busy_before_rst", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_ack0", ack0, 0);
    req0 = 1'b0;
    repeat (2) @(negedge pclk);
    rst = 1'b0;
    repeat (20) @(negedge pclk);
    chk("after_rst_idle", busy, 0);
    run_single(0, 8'h50, 10'd456, 8'h34, 8'h35, 8'h36);

`ifdef CHAR_BUF_VBLNK_GATE_EN
    begin
      int  seen;
      bit  got;
      vblnk_in = 1'b0;
      @(negedge pclk);
      addr0 = 8'h60; val0 = 10'd42; req0 = 1'b1;
      seen = 0;
      repeat (25) begin
        @(negedge pclk);
        if (wr_en) seen++;
      end
      chk("gate_hold_wr_en", seen, 0);
      chk("gate_hold_busy", busy, 1);
      expect_job(0, 8'h60, 8'h20, 8'h34, 8'h32, -1);
      vblnk_in = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
        @(negedge pclk);
        if (ack0) got = 1'b1;
      end
      req0 = 1'b0;
      if (!got) chk("gate_ack_timeout", 0, 1);
    end
`endif

    repeat (5) @(negedge pclk);
    chk("queue_empty", exp_q.size(), 0);
    chk("final_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
